// File: rtl/redundant_to_fp.sv
// Converts a redundant-form field element (signed carry + value per limb) into its canonical residue mod MOD.
// states: IDLE accept operand | RESOLVE one limb of the carry chain per cycle | REDUCE one +/-MOD step per cycle | DONE hold result
module redundant_to_fp #(
    parameter int ADD_DIV  = 4,
    parameter int W        = 64,
    parameter int MAX_ITER = 16,
    parameter logic [ADD_DIV*W-1:0] MOD =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADD_DIV*(W+8)-1:0]  din,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADD_DIV*W-1:0]      dout,
    output logic                      err
);
    localparam int NW  = ADD_DIV * W;
    localparam int AW  = NW + 10;
    localparam int LW  = W + 8;
    localparam int IW  = (ADD_DIV > 1) ? $clog2(ADD_DIV) : 1;
    localparam int NIW = $clog2(MAX_ITER + 1);
    localparam logic signed [AW-1:0] P_EXT = $signed({10'd0, MOD});

    typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_REDUCE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADD_DIV*LW-1:0]   din_q, din_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [9:0]       c_q, c_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NIW-1:0]          n_q, n_d;
    logic [NW-1:0]           dout_q, dout_d;
    logic                    err_q, err_d;

    logic [LW-1:0]           limb;
    logic signed [W+1:0]     s;
    logic signed [9:0]       c_nx;
    logic                    acc_neg, acc_ge;

    assign in_ready  = rstn && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dout      = dout_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        acc_d   = acc_q;
        c_d     = c_q;
        idx_d   = idx_q;
        n_d     = n_q;
        dout_d  = dout_q;
        err_d   = err_q;

        limb    = din_q[idx_q*LW +: LW];
        // Value is unsigned, running carry is signed: widen both by two bits before adding.
        s       = $signed({2'b00, limb[W-1:0]}) + $signed({{(W-8){c_q[9]}}, c_q});
        c_nx    = 10'(s >>> W) + {{2{limb[LW-1]}}, limb[LW-1:W]};
        acc_neg = acc_q[AW-1];
        acc_ge  = (acc_q >= P_EXT);

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    din_d   = din;
                    c_d     = '0;
                    idx_d   = '0;
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                acc_d[idx_q*W +: W] = s[W-1:0];
                c_d   = c_nx;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(ADD_DIV - 1)) begin
                    acc_d[AW-1 -: 10] = c_nx;
                    n_d     = '0;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (!acc_neg && !acc_ge) begin
                    dout_d  = acc_q[NW-1:0];
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (n_q == NIW'(MAX_ITER)) begin
                    dout_d  = acc_q[NW-1:0];
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_neg ? (acc_q + P_EXT) : (acc_q - P_EXT);
                    n_d   = n_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_redundant_to_fp.sv
// Randomized self-checking bench for redundant_to_fp against a big-integer reference model.
module tb_redundant_to_fp;
    localparam int ADD_DIV  = 4;
    localparam int W        = 64;
    localparam int LW       = W + 8;
    localparam int DW       = ADD_DIV * LW;
    localparam int NW       = ADD_DIV * W;
    localparam int MAX_ITER = 16;
    localparam logic [255:0] P =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, err;
    logic [DW-1:0] din = '0;
    logic [NW-1:0] dout;

    int    n_asserts = 0;
    int    n_fails = 0;
    string cur_op = "none";

    logic [63:0] vals[ADD_DIV];
    logic [7:0]  cars[ADD_DIV];

    always #5 clk = ~clk;

    redundant_to_fp #(.ADD_DIV(ADD_DIV), .W(W), .MAX_ITER(MAX_ITER), .MOD(P)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .err(err)
    );

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_op, tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_op();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < ADD_DIV; i++) d[i*LW +: LW] = {cars[i], vals[i]};
        return d;
    endfunction

    // Value = sum (val_i + carry_i*2^W) * 2^(iW), then bounded +/-p correction.
    function automatic void ref_model(input logic [DW-1:0] d, output logic [NW-1:0] r,
                                      output logic e, output int k);
        logic signed [299:0] v, p, t;
        logic [63:0] vb;
        logic [7:0]  cb;
        v = '0;
        p = $signed({44'd0, P});
        for (int i = 0; i < ADD_DIV; i++) begin
            vb = d[i*LW +: W];
            cb = d[i*LW+W +: 8];
            t  = $signed({236'd0, vb}) + ($signed({{292{cb[7]}}, cb}) <<< W);
            v  = v + (t <<< (W*i));
        end
        k = 0;
        e = 1'b0;
        while (v < 0 || v >= p) begin
            if (k == MAX_ITER) begin
                e = 1'b1;
                break;
            end
            if (v < 0) v = v + p;
            else       v = v - p;
            k++;
        end
        r = v[NW-1:0];
    endfunction

    task automatic run_op(input logic [DW-1:0] d, input bit bp);
        logic [NW-1:0] er, held;
        logic ee;
        int   ek, cnt;
        bit   stable;
        ref_model(d, er, ee, ek);
        @(negedge clk);
        out_ready = !bp;
        in_valid  = 1'b1;
        din       = d;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        din      = {9{$urandom()}};
        cnt = 0;
        while (!out_valid && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 5 + ek);
        chk("dout", dout, er);
        chk("err", err, ee);
        chk("in_ready_busy", in_ready, 0);
        if (bp) begin
            held   = dout;
            stable = 1'b1;
            for (int j = 0; j < 10; j++) begin
                @(posedge clk); #1;
                if (dout !== held || err !== ee || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
            end
            chk("bp_stable", stable, 1);
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic clear_op();
        for (int i = 0; i < ADD_DIV; i++) begin
            vals[i] = '0;
            cars[i] = '0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        cur_op = "reset";
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready", in_ready, 0);
        chk("out_valid", out_valid, 0);
        chk("dout", dout, 0);
        chk("err", err, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("in_ready_release", in_ready, 1);

        cur_op = "zero";
        clear_op();
        run_op(pack_op(), 1'b0);

        cur_op = "p";
        clear_op();
        for (int i = 0; i < ADD_DIV; i++) vals[i] = P[i*W +: W];
        run_op(pack_op(), 1'b0);

        cur_op = "minus_one";
        clear_op();
        vals[0] = '1;
        cars[0] = 8'hFF;
        run_op(pack_op(), 1'b0);

        cur_op = "carry_one";
        clear_op();
        vals[0] = '1;
        cars[0] = 8'h01;
        run_op(pack_op(), 1'b0);

        cur_op = "all_carry_7f";
        for (int i = 0; i < ADD_DIV; i++) begin
            vals[i] = {$urandom(), $urandom()};
            cars[i] = 8'h7F;
        end
        run_op(pack_op(), 1'b0);

        cur_op = "err_top";
        clear_op();
        cars[ADD_DIV-1] = 8'h7F;
        run_op(pack_op(), 1'b0);

        cur_op = "zero_after_err";
        clear_op();
        run_op(pack_op(), 1'b0);

        cur_op = "backpressure";
        for (int i = 0; i < ADD_DIV; i++) begin
            vals[i] = {$urandom(), $urandom()};
            cars[i] = 8'($urandom_range(0, 255));
        end
        cars[ADD_DIV-1] = 8'h01;
        run_op(pack_op(), 1'b1);

        cur_op = "reset_mid";
        clear_op();
        vals[0] = 64'h1234;
        @(negedge clk);
        in_valid = 1'b1;
        din      = pack_op();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("in_ready_in_reset", in_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("in_ready_release", in_ready, 1);
        seen = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_output", seen, 0);

        for (int n = 0; n < 40; n++) begin
            cur_op = $sformatf("rand%0d", n);
            for (int i = 0; i < ADD_DIV; i++) begin
                vals[i] = {$urandom(), $urandom()};
                cars[i] = 8'($urandom_range(0, 255));
            end
            case ($urandom_range(0, 4))
                0: cars[ADD_DIV-1] = 8'h00;
                1: cars[ADD_DIV-1] = 8'hFF;
                2: cars[ADD_DIV-1] = 8'h01;
                3: begin
                    cars[ADD_DIV-1] = 8'h00;
                    vals[ADD_DIV-1] = 64'($urandom_range(0, 7)) << 60;
                end
                default: ;
            endcase
            run_op(pack_op(), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule

// File: doc/redundant_to_fp.md
# redundant_to_fp

Converts one redundant-form field element into a canonical integer in [0, p). The input is `redundant_poly_L3`, as produced on `postadder` `dout`: ADD_DIV limbs, each an 8-bit signed carry plus a `fp_div4_t` value. The block sits downstream of the postadder, at the point where results leave the redundant domain for memory or host readback. It resolves carries serially, one limb per cycle, then applies iterative ±p correction, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `MAX_ITER`, default 16: maximum number of ±p corrections before the block flags an error.
- Field modulus: `PARAMS_BN254_d0::Mod`. Limb count: `ADD_DIV`. W = `$bits(fp_div4_t)`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `din` is valid.
- `in_ready`  out  1  block accepts `din`; equals `rstn && state==IDLE`.
- `din`  in  `redundant_poly_L3`  redundant operand.
- `out_valid`  out  1  `dout`/`err` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `dout`  out  `uint_fp_t`  canonical result, registered.
- `err`  out  1  correction limit was hit; `dout` is not canonical.

## Operation
- Value of `din`: sum over i of (val_i + carry_i·2^W)·2^(iW).
  - carry_i is signed two's complement.
  - val_i is unsigned.
- Internal accumulator `acc`: signed, ADD_DIV·W+10 bits.
- Running carry `c`: signed, 10 bits.
- State machine:
  - IDLE: on `in_valid && in_ready`, latch `din`, clear `c` and limb index `i`, then go to RESOLVE.
  - RESOLVE: one limb per cycle, i = 0..ADD_DIV-1.
    - s = val_i + c (signed).
    - acc limb i = s[W-1:0].
    - c = (s >>> W) + sext(carry_i).
    - After limb ADD_DIV-1, acc top bits = sext(c). Go to REDUCE with iteration count n=0.
  - REDUCE: one decision per cycle.
    - If acc<0: acc += p, n++.
    - Else if acc ≥ p: acc −= p, n++.
    - Else: go to DONE with err=0.
    - If n reaches `MAX_ITER` while acc is still out of range: go to DONE with err=1 and dout = acc[low bits].
  - DONE: `out_valid`=1. `dout`/`err` held stable until `out_ready`=1. On the handshake, go to IDLE.
- Only one operation is in flight at a time. `in_ready`=0 in RESOLVE, REDUCE and DONE.
- `din` is ignored when `in_ready`=0. No input buffering.

## Timing
- Reset, applied whenever `rstn`=0 at an edge:
  - state=IDLE.
  - `out_valid`=0, `dout`=0, `err`=0.
  - `in_ready`=0 while `rstn` is low, 1 from the first cycle after release.
- Reset mid-operation aborts the operation. No output is produced for the aborted operand.
- Latency: accept in cycle T. `out_valid` first rises in cycle T+ADD_DIV+k+2, where k is the number of corrections applied (k ≤ `MAX_ITER`).
  - With ADD_DIV=4 and k=0: T+6.
- The error case takes `MAX_ITER` corrections; `out_valid` rises at T+ADD_DIV+MAX_ITER+2.
- The output handshake completes in cycle D when `out_valid && out_ready`. `in_ready`=1 in D+1, so throughput is at most one result every ADD_DIV+k+3 cycles.
- `out_ready` high before `out_valid` has no effect.
- `out_valid` never depends combinationally on `out_ready`.

## Test plan
- `din`=0, `out_ready`=1, accept at T → `dout`=0, `err`=0, `out_valid` for exactly one cycle at T+6.
- `din` = p (carries 0, vals = limbs of p) → `dout`=0 at T+7 (k=1).
- `din`: val0=2^W−1, carry0=8'hFF, all others 0 (value −1) → `dout`=p−1, `err`=0 at T+7.
- `din`: val0=2^W−1, carry0=1, others 0 → `dout`=2^(W+1)−1, k=0, at T+6. Also confirm carry propagation across all limbs with every carry_i=8'h7F against a bit-accurate model.
- `din`: carry(ADD_DIV−1)=8'h7F, `MAX_ITER`=16 → `err`=1 and `out_valid` at T+22. Then the next operand 0 is accepted and yields `dout`=0, `err`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `dout` stable and `in_ready`=0 throughout. Additionally, pulse `rstn`=0 during RESOLVE → `out_valid` stays 0 and `in_ready`=1 the cycle after release.
